// File: rtl/mysystem_sysinfo_pkg.sv
// Shared definitions for the mysystem_sysinfo slave.
// Contents: register word offsets, the CAPS version code, CTRL bit positions,
// the uptime counter width, and a byte-lane merge helper used by every
// writable register.
package mysystem_sysinfo_pkg;

    // Register word offsets
    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] ADDR_CAPS      = 4'd2;
    localparam logic [3:0] ADDR_CTRL      = 4'd3;
    localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] ADDR_MS_COUNT  = 4'd6;
    localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

    // Capability word version field
    localparam logic [7:0] VERSION = 8'h02;

    // CTRL bit positions
    localparam int EN_BIT  = 0;
    localparam int CLR_BIT = 1;

    // Free-running uptime counter width
    localparam int UPTIME_W = 64;

    // Merge write data into a register, one byte lane per byteenable bit.
    function automatic logic [31:0] apply_be(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wd[8*b +: 8];
            end else begin
                res[8*b +: 8] = cur[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mysystem_sysinfo_timebase.sv
// Time base for mysystem_sysinfo: 64-bit uptime counter, millisecond
// prescaler with a 32-bit millisecond count, and the uptime high-word
// snapshot register.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   en            counting enable (freezes all counters when low)
//   clr           zero uptime, prescaler and ms count this edge (beats en)
//   snap_req      capture uptime[63:32] into the snapshot this edge
//   uptime_lo     current uptime[31:0] (pre-increment value at the edge)
//   snap_hi       captured high word
//   ms_count      millisecond count
module mysystem_sysinfo_timebase
    import mysystem_sysinfo_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        snap_req,
    output logic [31:0] uptime_lo,
    output logic [31:0] snap_hi,
    output logic [31:0] ms_count
);

    localparam int             PRESCALE = CLK_HZ / 1000;
    localparam int             PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [UPTIME_W-1:0] uptime_r;
    logic [PS_W-1:0]     ps_r;
    logic [31:0]         ms_r;
    logic [31:0]         snap_r;

    // Counters: clr wins over the increment; en=0 holds everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime_r <= '0;
            ps_r     <= '0;
            ms_r     <= 32'd0;
        end else if (clr) begin
            uptime_r <= '0;
            ps_r     <= '0;
            ms_r     <= 32'd0;
        end else if (en) begin
            uptime_r <= uptime_r + 64'd1;
            if (ps_r == PS_MAX) begin
                ps_r <= '0;
                ms_r <= ms_r + 32'd1;
            end else begin
                ps_r <= ps_r + PS_ONE;
                ms_r <= ms_r;
            end
        end else begin
            uptime_r <= uptime_r;
            ps_r     <= ps_r;
            ms_r     <= ms_r;
        end
    end

    // Snapshot takes the pre-increment high word, matching the low word
    // returned by the same read, so LO-then-HI is a coherent 64-bit value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_r <= 32'd0;
        end else if (snap_req) begin
            snap_r <= uptime_r[63:32];
        end else begin
            snap_r <= snap_r;
        end
    end

    assign uptime_lo = uptime_r[31:0];
    assign snap_hi   = snap_r;
    assign ms_count  = ms_r;

endmodule

// File: rtl/mysystem_sysinfo.sv
// System-information Avalon-MM slave: build ID, build timestamp, capability
// word, control register, uptime/millisecond time base and scratch registers.
// Fixed read latency of one cycle, no waitrequest.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   address        word address (4 bits)
//   read, write    transfer strobes, one transfer per asserted cycle
//   writedata      write data
//   byteenable     byte lanes for writes
//   readdata       registered read data, holds between reads
//   readdatavalid  one-cycle pulse one edge after each accepted read
module mysystem_sysinfo
    import mysystem_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 2,
    parameter int          CLK_HZ      = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0]  SCR_CNT = 4'(NUM_SCRATCH);
    localparam logic [31:0] CAPS    = {20'd0, SCR_CNT, VERSION};

    logic        en_r;
    logic        ctrl_wr_s;
    logic        clr_s;
    logic        snap_req_s;
    logic [31:0] uptime_lo_s;
    logic [31:0] snap_hi_s;
    logic [31:0] ms_count_s;
    logic [31:0] scratch_s [0:7];
    logic [31:0] rd_mux_s;
    logic [31:0] readdata_r;
    logic        readdatavalid_r;

    // CTRL only responds through byte lane 0, where both bits live.
    assign ctrl_wr_s  = write && (address == ADDR_CTRL) && byteenable[0];
    assign clr_s      = ctrl_wr_s && writedata[CLR_BIT];
    assign snap_req_s = read && (address == ADDR_UPTIME_LO);

    // EN register; a new value applies from the cycle after the write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_r <= 1'b1;
        end else if (ctrl_wr_s) begin
            en_r <= writedata[EN_BIT];
        end else begin
            en_r <= en_r;
        end
    end

    mysystem_sysinfo_timebase #(
        .CLK_HZ (CLK_HZ)
    ) u_timebase (
        .clock     (clock),
        .reset     (reset),
        .en        (en_r),
        .clr       (clr_s),
        .snap_req  (snap_req_s),
        .uptime_lo (uptime_lo_s),
        .snap_hi   (snap_hi_s),
        .ms_count  (ms_count_s)
    );

    // Scratch slots beyond NUM_SCRATCH are tied to zero.
    for (genvar i = 0; i < 8; i++) begin : g_scratch
        if (i < NUM_SCRATCH) begin : g_impl
            logic [31:0] scr_r;

            // One scratch register with per-lane writes.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    scr_r <= 32'd0;
                end else if (write && (address == 4'(8 + i))) begin
                    scr_r <= apply_be(scr_r, writedata, byteenable);
                end else begin
                    scr_r <= scr_r;
                end
            end

            assign scratch_s[i] = scr_r;
        end else begin : g_absent
            assign scratch_s[i] = 32'd0;
        end
    end

    // Read decode; offset 7 and unmapped offsets fall to zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_ID:        rd_mux_s = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux_s = TIMESTAMP;
            ADDR_CAPS:      rd_mux_s = CAPS;
            ADDR_CTRL:      rd_mux_s = {31'd0, en_r};
            ADDR_UPTIME_LO: rd_mux_s = uptime_lo_s;
            ADDR_UPTIME_HI: rd_mux_s = snap_hi_s;
            ADDR_MS_COUNT:  rd_mux_s = ms_count_s;
            default: begin
                if (address[3] && ({1'b0, address[2:0]} < SCR_CNT)) begin
                    rd_mux_s = scratch_s[address[2:0]];
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
        endcase
    end

    // Read response register; data captured from pre-write state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= read;
            if (read) begin
                readdata_r <= rd_mux_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_mysystem_sysinfo.sv
// Directed testbench for mysystem_sysinfo (SYSTEM_ID=5EDA_8F33,
// NUM_SCRATCH=2, CLK_HZ=2000 so the millisecond prescale is 2).
module tb_mysystem_sysinfo;

    localparam logic [31:0] ID = 32'h5EDA_8F33;
    localparam logic [31:0] TS = 32'h6543_2100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = 4'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mysystem_sysinfo #(
        .SYSTEM_ID   (ID),
        .TIMESTAMP   (TS),
        .NUM_SCRATCH (2),
        .CLK_HZ      (2000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single read: accepted at the next posedge, checked on the following negedge.
    task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        check({tag, "_rdv"}, {31'd0, readdatavalid}, 32'd1);
        check(tag, readdata, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write      = 1'b0;
        byteenable = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        reset = 1'b0;

        // Counting begins at the first edge after release; snapshot resets to 0
        rd(4'd4, "up_first", 32'd0);
        rd(4'd4, "up_second", 32'd1);
        rd(4'd5, "snap_rst", 32'd0);

        // Back-to-back reads of ID, TIMESTAMP, CAPS then idle
        address = 4'd0;
        read    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("b2b_rdv0", {31'd0, readdatavalid}, 32'd1);
        check("id", readdata, ID);
        address = 4'd1;
        @(posedge clock);
        @(negedge clock);
        check("b2b_rdv1", {31'd0, readdatavalid}, 32'd1);
        check("timestamp", readdata, TS);
        address = 4'd2;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
        check("b2b_rdv2", {31'd0, readdatavalid}, 32'd1);
        check("caps", readdata, 32'h0000_0202);
        @(posedge clock);
        @(negedge clock);
        check("idle_rdv", {31'd0, readdatavalid}, 32'd0);
        check("idle_hold", readdata, 32'h0000_0202);

        // Fixed map reads and unmapped offsets
        rd(4'd3, "ctrl_rst", 32'd1);
        rd(4'd7, "off7", 32'd0);
        rd(4'd15, "off15", 32'd0);
        wr(4'd0, 32'hFFFF_FFFF, 4'hF);
        rd(4'd0, "id_ro", ID);

        // Scratch byte lanes and range
        wr(4'd8, 32'hA5A5_A5A5, 4'b0101);
        rd(4'd8, "scr8_be", 32'h00A5_00A5);
        wr(4'd9, 32'h1234_5678, 4'hF);
        rd(4'd9, "scr9", 32'h1234_5678);
        rd(4'd8, "scr8_keep", 32'h00A5_00A5);
        wr(4'd8, 32'hFFFF_FFFF, 4'b1000);
        rd(4'd8, "scr8_lane3", 32'hFFA5_00A5);
        wr(4'd10, 32'hDEAD_BEEF, 4'hF);
        rd(4'd10, "scr10_absent", 32'd0);

        // Read and write of the same register in one cycle returns old contents
        address    = 4'd9;
        writedata  = 32'hCAFE_F00D;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'd0;
        check("rw_same", readdata, 32'h1234_5678);
        rd(4'd9, "rw_after", 32'hCAFE_F00D);

        // CTRL ignores writes without lane 0
        wr(4'd3, 32'h0000_0000, 4'b1110);
        rd(4'd3, "ctrl_lane", 32'd1);

        // Snapshot holds the pre-carry high word
        force dut.u_timebase.uptime_r = 64'h0000_0007_FFFF_FFFF;
        address = 4'd4;
        read    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        release dut.u_timebase.uptime_r;
        read = 1'b0;
        check("carry_lo", readdata, 32'hFFFF_FFFF);
        rd(4'd5, "carry_hi", 32'h0000_0007);

        // CLR with EN: next read of uptime sees the cleared value, CTRL reads 1
        wr(4'd3, 32'd3, 4'hF);
        rd(4'd4, "clr_up", 32'd0);
        rd(4'd3, "ctrl_after_clr", 32'd1);

        // Millisecond counter with prescale 2, then freeze
        wr(4'd3, 32'd3, 4'hF);
        repeat (10) @(negedge clock);
        rd(4'd6, "ms_10", 32'd5);
        rd(4'd4, "up_11", 32'd11);
        wr(4'd3, 32'd0, 4'hF);
        rd(4'd4, "frz_up_a", 32'd13);
        rd(4'd6, "frz_ms_a", 32'd6);
        repeat (20) @(negedge clock);
        rd(4'd4, "frz_up_b", 32'd13);
        rd(4'd6, "frz_ms_b", 32'd6);
        rd(4'd3, "ctrl_off", 32'd0);

        // Reset one cycle after a read drops the pending valid
        address = 4'd0;
        read    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clock);
        check("rst_mid_rdv", {31'd0, readdatavalid}, 32'd0);
        check("rst_mid_rdata", readdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rd(4'd5, "rst_snap", 32'd0);
        rd(4'd4, "rst_up", 32'd1);
        rd(4'd3, "rst_ctrl", 32'd1);
        rd(4'd8, "rst_scr8", 32'd0);
        rd(4'd9, "rst_scr9", 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
